// File: rtl/ahfp_mult.sv
// +------------------------------------------------------------------------+
// | ahfp_mult : 2-stage IEEE-754 binary32 multiplier, RNE, denormals FTZ    |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
`default_nettype none

module ahfp_mult (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        out_valid,
  output logic [31:0] result
);

  localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

  // Stage 1 state
  logic               valid1_q, valid1_d;
  logic               sign1_q, sign1_d;
  logic signed [9:0]  exp1_q, exp1_d;
  logic [47:0]        prod1_q, prod1_d;
  logic               nan1_q, nan1_d;
  logic               inf1_q, inf1_d;
  logic               zero1_q, zero1_d;

  // Output state
  logic               out_valid_q, out_valid_d;
  logic [31:0]        result_q, result_d;

  // Stage 1 operand decode
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  always_comb begin
    ea     = dataa[30:23];
    eb     = datab[30:23];
    fa     = dataa[22:0];
    fb     = datab[22:0];
    // A zero exponent is zero whatever the fraction: denormals are flushed.
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);

    valid1_d = in_valid;
    sign1_d  = dataa[31] ^ datab[31];
    exp1_d   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    prod1_d  = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
    nan1_d   = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
    inf1_d   = (a_inf | b_inf) & ~nan1_d;
    zero1_d  = (a_zero | b_zero) & ~nan1_d & ~inf1_d;
  end

  // Stage 2 normalise and round
  logic               prod_hi;
  logic [23:0]        mant;
  logic               guard, sticky, round_up;
  logic [24:0]        mant_r;
  logic signed [9:0]  exp_n, exp_f;
  logic [22:0]        frac;
  logic [31:0]        packed_res;

  always_comb begin
    prod_hi  = prod1_q[47];
    mant     = prod_hi ? prod1_q[47:24] : prod1_q[46:23];
    guard    = prod_hi ? prod1_q[23] : prod1_q[22];
    sticky   = prod_hi ? (|prod1_q[22:0]) : (|prod1_q[21:0]);
    exp_n    = exp1_q + $signed({9'd0, prod_hi});
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {24'd0, round_up};
    // Carry out of rounding means the mantissa became exactly 2.0.
    exp_f    = exp_n + $signed({9'd0, mant_r[24]});
    frac     = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    if (nan1_q) begin
      packed_res = C_QNAN;
    end else if (inf1_q) begin
      packed_res = {sign1_q, 8'hFF, 23'd0};
    end else if (zero1_q) begin
      packed_res = {sign1_q, 31'd0};
    end else if (exp_f >= 10'sd255) begin
      packed_res = {sign1_q, 8'hFF, 23'd0};
    end else if (exp_f <= 10'sd0) begin
      packed_res = {sign1_q, 31'd0};
    end else begin
      packed_res = {sign1_q, exp_f[7:0], frac};
    end

    out_valid_d = valid1_q;
    result_d    = valid1_q ? packed_res : result_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid1_q    <= 1'b0;
      sign1_q     <= 1'b0;
      exp1_q      <= 10'sd0;
      prod1_q     <= 48'd0;
      nan1_q      <= 1'b0;
      inf1_q      <= 1'b0;
      zero1_q     <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
    end else begin
      valid1_q    <= valid1_d;
      sign1_q     <= sign1_d;
      exp1_q      <= exp1_d;
      prod1_q     <= prod1_d;
      nan1_q      <= nan1_d;
      inf1_q      <= inf1_d;
      zero1_q     <= zero1_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

`default_nettype wire

// File: tb/tb_ahfp_mult.sv
// +------------------------------------------------------------------------+
// | tb_ahfp_mult : directed-vector bench for ahfp_mult                      |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_ahfp_mult;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        out_valid;
  logic [31:0] result;

  int checks;
  int errors;

  logic [31:0] tv_a [15];
  logic [31:0] tv_b [15];
  logic [31:0] tv_r [15];

  ahfp_mult dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .dataa     (dataa),
    .datab     (datab),
    .out_valid (out_valid),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation for one cycle; returns 1 time unit after the capture edge.
  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    dataa    = a;
    datab    = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b result=%h, required out_valid=0 result=00000000",
               out_valid, result);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 2; i++) begin
      drive(tv_a[i], tv_b[i]);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_latency1[%0d]: out_valid=%b, required 0", i, out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== tv_r[i]) begin
        errors++;
        $display("FAIL basic[%0d]: out_valid=%b result=%h, required 1 %h", i, out_valid, result, tv_r[i]);
      end
    end
  endtask

  task automatic test_rounding();
    for (int i = 2; i < 6; i++) begin
      drive(tv_a[i], tv_b[i]);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== tv_r[i]) begin
        errors++;
        $display("FAIL rounding[%0d]: out_valid=%b result=%h, required 1 %h", i, out_valid, result, tv_r[i]);
      end
    end
  endtask

  task automatic test_signs();
    for (int i = 6; i < 8; i++) begin
      drive(tv_a[i], tv_b[i]);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== tv_r[i]) begin
        errors++;
        $display("FAIL signs[%0d]: out_valid=%b result=%h, required 1 %h", i, out_valid, result, tv_r[i]);
      end
    end
  endtask

  task automatic test_zero_underflow();
    for (int i = 8; i < 11; i++) begin
      drive(tv_a[i], tv_b[i]);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== tv_r[i]) begin
        errors++;
        $display("FAIL zero_uflow[%0d]: out_valid=%b result=%h, required 1 %h", i, out_valid, result, tv_r[i]);
      end
    end
  endtask

  task automatic test_specials();
    for (int i = 11; i < 15; i++) begin
      drive(tv_a[i], tv_b[i]);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== tv_r[i]) begin
        errors++;
        $display("FAIL specials[%0d]: out_valid=%b result=%h, required 1 %h", i, out_valid, result, tv_r[i]);
      end
    end
  endtask

  // Result must hold the last product while no new result is valid.
  task automatic test_hold();
    drive(tv_a[2], tv_b[2]);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || result !== tv_r[2]) begin
        errors++;
        $display("FAIL hold[%0d]: out_valid=%b result=%h, required 0 %h", k, out_valid, result, tv_r[2]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      if (i < 11) begin
        dataa    = tv_a[i];
        datab    = tv_b[i];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (i >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || result !== tv_r[i-1]) begin
          errors++;
          $display("FAIL b2b[%0d]: out_valid=%b result=%h, required 1 %h", i - 1, out_valid, result, tv_r[i-1]);
        end
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    dataa    = tv_a[14];
    datab    = tv_b[14];
    in_valid = 1'b1;
    @(posedge clk); #1;
    dataa    = tv_a[4];
    datab    = tv_b[4];
    reset    = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: out_valid=%b result=%h, required 0 00000000", out_valid, result);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || result !== 32'h0) begin
        errors++;
        $display("FAIL rst_stale[%0d]: out_valid=%b result=%h, required 0 00000000", k, out_valid, result);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    dataa    = 32'h0;
    datab    = 32'h0;

    tv_a[0]  = 32'h3F800000; tv_b[0]  = 32'h40000000; tv_r[0]  = 32'h40000000;
    tv_a[1]  = 32'h40000000; tv_b[1]  = 32'h40800000; tv_r[1]  = 32'h41000000;
    tv_a[2]  = 32'h40400000; tv_b[2]  = 32'h40600000; tv_r[2]  = 32'h41280000;
    tv_a[3]  = 32'h40A00000; tv_b[3]  = 32'h41133333; tv_r[3]  = 32'h42380000;
    tv_a[4]  = 32'h41EC0000; tv_b[4]  = 32'h42160000; tv_r[4]  = 32'h448A4800;
    tv_a[5]  = 32'h42FF999A; tv_b[5]  = 32'h42FCCCCD; tv_r[5]  = 32'h467C67AF;
    tv_a[6]  = 32'hC6A5E51F; tv_b[6]  = 32'hC6AE9357; tv_r[6]  = 32'h4DE2426C;
    tv_a[7]  = 32'hC640E400; tv_b[7]  = 32'h47F12040; tv_r[7]  = 32'hCEB5AEF1;
    tv_a[8]  = 32'h00000000; tv_b[8]  = 32'h00000000; tv_r[8]  = 32'h00000000;
    tv_a[9]  = 32'h00C00000; tv_b[9]  = 32'h00C00000; tv_r[9]  = 32'h00000000;
    tv_a[10] = 32'h80000000; tv_b[10] = 32'h3F800000; tv_r[10] = 32'h80000000;
    tv_a[11] = 32'h7F000000; tv_b[11] = 32'h40000000; tv_r[11] = 32'h7F800000;
    tv_a[12] = 32'h7F800000; tv_b[12] = 32'h00000000; tv_r[12] = 32'h7FC00000;
    tv_a[13] = 32'h7F800000; tv_b[13] = 32'hBF800000; tv_r[13] = 32'hFF800000;
    tv_a[14] = 32'h7FC00001; tv_b[14] = 32'h3F800000; tv_r[14] = 32'h7FC00000;

    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_rounding();
    test_signs();
    test_zero_underflow();
    test_specials();
    test_hold();
    test_back_to_back();
    test_reset_midflight();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
